// File: rtl/waveform_player_if.sv
// waveform_player_if: DMA read port and SPI DAC master handshake bundle
interface waveform_player_if #(
    parameter int RAM_WID      = 32,
    parameter int RAM_WORD_WID = 16,
    parameter int DAC_WID      = 24
);
    logic [RAM_WID-1:0]      ram_dma_addr;
    logic                    ram_read;
    logic [RAM_WORD_WID-1:0] ram_word;
    logic                    ram_valid;
    logic [DAC_WID-1:0]      dac_out;
    logic                    dac_arm;
    logic                    dac_finished;

    modport master (
        output ram_dma_addr, ram_read, dac_out, dac_arm,
        input  ram_word, ram_valid, dac_finished
    );

    modport slave (
        input  ram_dma_addr, ram_read, dac_out, dac_arm,
        output ram_word, ram_valid, dac_finished
    );
endinterface

// File: rtl/waveform_player.sv
// waveform_player: streams RAM samples to an SPI DAC with prefetch, looping and underrun detection
module waveform_player #(
    parameter int WORD_WID       = 20,
    parameter int RAM_WID        = 32,
    parameter int RAM_WORD_WID   = 16,
    parameter int RAM_WORD_INCR  = 2,
    parameter int SAMPLE_CNT_WID = 11,
    parameter int LOOP_CNT_WID   = 16,
    parameter int TIMER_WID      = 32,
    parameter int DAC_WID        = 24,
    parameter logic [DAC_WID-WORD_WID-1:0] DAC_PREFIX = 4'b0001
) (
    input  logic                      clk,
    input  logic                      rst_L,
    input  logic                      arm,
    input  logic [RAM_WID-1:0]        start_addr,
    input  logic [SAMPLE_CNT_WID-1:0] sample_count,
    input  logic [LOOP_CNT_WID-1:0]   loop_count,
    input  logic [TIMER_WID-1:0]      time_to_wait,
    output logic                      running,
    output logic                      finished,
    output logic                      underrun,
    output logic [SAMPLE_CNT_WID-1:0] samples_left,
    output logic [LOOP_CNT_WID-1:0]   loops_left,
    waveform_player_if.master         bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]                state;
    logic [RAM_WID-1:0]        base;
    logic [SAMPLE_CNT_WID-1:0] pass_len;
    logic [LOOP_CNT_WID-1:0]   pass_cnt;
    logic [TIMER_WID-1:0]      wait_len;
    logic [TIMER_WID-1:0]      timer;
    logic [RAM_WORD_WID-1:0]   lo;
    logic [WORD_WID-1:0]       sample;
    logic                      hi_phase;
    logic                      full;
    logic                      exhausted;
    logic                      first;
    logic [SAMPLE_CNT_WID-1:0] fetch_left;
    logic [LOOP_CNT_WID-1:0]   fetch_loops;
    logic                      start;
    logic                      emit;
    logic                      dac_done;
    logic                      more_passes;
    logic                      fetch_more;

    // Handshake qualifiers shared by the fetch engine and the control FSM
    always_comb begin
        start       = state == IDLE && arm && sample_count != '0;
        emit        = state == RUN && arm && !bus.dac_arm && timer == '0 && full;
        dac_done    = bus.dac_arm && bus.dac_finished;
        more_passes = pass_cnt == '0 || loops_left > LOOP_CNT_WID'(1);
        fetch_more  = pass_cnt == '0 || fetch_loops > LOOP_CNT_WID'(1);
        running     = state != IDLE;
    end

    // Fetch engine: two RAM reads per sample (low word first) into a one-sample buffer
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            bus.ram_dma_addr <= '0;
            bus.ram_read     <= 1'b0;
            hi_phase         <= 1'b0;
            lo               <= '0;
            sample           <= '0;
            full             <= 1'b0;
            exhausted        <= 1'b0;
            fetch_left       <= '0;
            fetch_loops      <= '0;
        end else if (start) begin
            bus.ram_dma_addr <= start_addr;
            bus.ram_read     <= 1'b1;
            hi_phase         <= 1'b0;
            full             <= 1'b0;
            exhausted        <= 1'b0;
            fetch_left       <= sample_count;
            fetch_loops      <= loop_count;
        end else if (bus.ram_read) begin
            if (bus.ram_valid) begin
                bus.ram_read <= 1'b0;
                if (!hi_phase) begin
                    lo               <= bus.ram_word;
                    hi_phase         <= 1'b1;
                    bus.ram_dma_addr <= bus.ram_dma_addr + RAM_WID'(RAM_WORD_INCR);
                end else begin
                    hi_phase <= 1'b0;
                    if (state == RUN) begin
                        sample <= {bus.ram_word[WORD_WID-RAM_WORD_WID-1:0], lo};
                        full   <= 1'b1;
                        if (fetch_left == SAMPLE_CNT_WID'(1)) begin
                            if (fetch_more) begin
                                bus.ram_dma_addr <= base;
                                fetch_left       <= pass_len;
                                if (pass_cnt != '0)
                                    fetch_loops <= fetch_loops - LOOP_CNT_WID'(1);
                            end else begin
                                fetch_left <= '0;
                                exhausted  <= 1'b1;
                            end
                        end else begin
                            fetch_left       <= fetch_left - SAMPLE_CNT_WID'(1);
                            bus.ram_dma_addr <= bus.ram_dma_addr + RAM_WID'(RAM_WORD_INCR);
                        end
                    end
                end
            end
        end else if (emit) begin
            full <= 1'b0;
        end else if (state == RUN && arm && !full && !exhausted) begin
            bus.ram_read <= 1'b1;
        end
    end

    // Control FSM: configuration latch, paced emission, pass/loop accounting, abort drain
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state        <= IDLE;
            finished     <= 1'b0;
            underrun     <= 1'b0;
            samples_left <= '0;
            loops_left   <= '0;
            bus.dac_out  <= '0;
            bus.dac_arm  <= 1'b0;
            timer        <= '0;
            first        <= 1'b0;
            base         <= '0;
            pass_len     <= '0;
            pass_cnt     <= '0;
            wait_len     <= '0;
        end else begin
            case (state)
                IDLE: if (arm) begin
                    base         <= start_addr;
                    pass_len     <= sample_count;
                    pass_cnt     <= loop_count;
                    wait_len     <= time_to_wait;
                    samples_left <= sample_count;
                    loops_left   <= loop_count;
                    underrun     <= 1'b0;
                    timer        <= '0;
                    first        <= 1'b1;
                    finished     <= sample_count == '0;
                    state        <= sample_count == '0 ? DONE : RUN;
                end
                RUN: begin
                    if (dac_done) begin
                        bus.dac_arm <= 1'b0;
                        timer       <= wait_len;
                        if (arm && samples_left == '0) begin
                            if (more_passes) begin
                                samples_left <= pass_len;
                                if (pass_cnt != '0)
                                    loops_left <= loops_left - LOOP_CNT_WID'(1);
                            end else begin
                                finished <= 1'b1;
                                state    <= DONE;
                            end
                        end
                    end else if (emit) begin
                        bus.dac_out <= {DAC_PREFIX, sample};
                        bus.dac_arm <= 1'b1;
                        first       <= 1'b0;
                        if (samples_left != '0)
                            samples_left <= samples_left - SAMPLE_CNT_WID'(1);
                    end else if (timer != '0) begin
                        timer <= timer - TIMER_WID'(1);
                    end else if (arm && !first && !bus.dac_arm && !full) begin
                        underrun <= 1'b1;
                    end
                    if (!arm)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (dac_done)
                        bus.dac_arm <= 1'b0;
                    if ((!bus.dac_arm || bus.dac_finished) && (!bus.ram_read || bus.ram_valid))
                        state <= IDLE;
                end
                default: if (!arm) begin
                    finished <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule
